// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit with an optional accumulator operand and a
// 2-entry output FIFO carrying {y, zero, parity}, valid/ready on both sides.
module logic_unit_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             acc_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             parity
);

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NAND = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOT  = 3'd6,
    OP_PASS = 3'd7
  } op_e;

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             parity;
  } entry_t;

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] bsel, r;
  entry_t           head_q, head_d, tail_q, tail_d, new_e;
  logic [1:0]       count_q, count_d;
  logic             push, pop;

  always_comb begin
    bsel = acc_mode ? acc_q : b;
    // NOTE: the default branch gives r a value on every path, so no latch is inferred.
    case (op_e'(op))
      OP_AND:  r = a & bsel;
      OP_OR:   r = a | bsel;
      OP_NAND: r = ~(a & bsel);
      OP_NOR:  r = ~(a | bsel);
      OP_XOR:  r = a ^ bsel;
      OP_XNOR: r = ~(a ^ bsel);
      OP_NOT:  r = ~a;
      default: r = a;
    endcase
    new_e.y      = r;
    new_e.zero   = (r == '0);
    new_e.parity = ^r;
  end

  // A pop in the same cycle frees a slot, so a full buffer still accepts.
  assign in_ready  = (count_q != 2'd2) | out_ready;
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    acc_d   = acc_q;
    count_d = count_q + {1'b0, push} - {1'b0, pop};
    if (push && acc_mode) acc_d = r;
    case (count_q)
      2'd0: if (push) head_d = new_e;
      2'd1: begin
        if (push && pop) head_d = new_e;
        else if (push)   tail_d = new_e;
      end
      default: begin
        if (pop) begin
          head_d = tail_q;
          if (push) tail_d = new_e;
        end
      end
    endcase
  end

  // Head keeps the last popped entry when the buffer drains, which is what y shows.
  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
    if (!rst_n) begin
      count_q <= 2'd0;
      acc_q   <= '0;
      head_q  <= '{y: '0, zero: 1'b1, parity: 1'b0};
    end else begin
      count_q <= count_d;
      acc_q   <= acc_d;
      head_q  <= head_d;
    end
  end

  // NOTE: the tail slot is storage only; it is never observed before a push writes it, so it has no reset.
  always_ff @(posedge clk) begin
    tail_q <= tail_d;
  end

  assign y      = head_q.y;
  assign zero   = head_q.zero;
  assign parity = head_q.parity;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: directed scenarios plus a random
// stream compared against a queue-based reference model.
module tb_logic_unit_pipe;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic             acc_mode;
  logic [WIDTH-1:0] a, b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             zero;
  logic             parity;

  logic_unit_pipe #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .acc_mode(acc_mode), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .y(y), .zero(zero), .parity(parity)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             parity;
  } item_t;

  item_t            mq[$];
  item_t            last_pop;
  logic [WIDTH-1:0] m_acc;
  logic             got_in_ready;
  logic             exp_in_ready;
  int               n_checks = 0;
  int               n_fail = 0;

  function automatic logic [WIDTH-1:0] ref_fn(input logic [2:0] o,
                                              input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] z);
    case (o)
      3'd0: return x & z;
      3'd1: return x | z;
      3'd2: return ~(x & z);
      3'd3: return ~(x | z);
      3'd4: return x ^ z;
      3'd5: return ~(x ^ z);
      3'd6: return ~x;
      default: return x;
    endcase
  endfunction

  function automatic item_t model_head();
    return (mq.size() > 0) ? mq[0] : last_pop;
  endfunction

  // One clock: drive at the falling edge, capture in_ready, advance the model on the rising edge.
  task automatic step(input logic iv, input logic [2:0] o, input logic am,
                      input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                      input logic ordy);
    logic  acc_now, pop_now;
    item_t it;
    in_valid = iv; op = o; acc_mode = am; a = av; b = bv; out_ready = ordy;
    #1;
    got_in_ready = in_ready;
    exp_in_ready = (mq.size() < 2) || ordy;
    acc_now = iv && exp_in_ready;
    pop_now = (mq.size() > 0) && ordy;
    it.y      = ref_fn(o, av, am ? m_acc : bv);
    it.zero   = (it.y == 0);
    it.parity = ^it.y;
    @(posedge clk);
    if (pop_now) last_pop = mq.pop_front();
    if (acc_now) begin
      mq.push_back(it);
      if (am) m_acc = it.y;
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    @(posedge clk);
    mq.delete();
    m_acc = '0;
    last_pop.y = '0; last_pop.zero = 1'b1; last_pop.parity = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) step(1'b0, 3'd0, 1'b0, '0, '0, 1'b1);
  endtask

  task automatic test_reset();
    in_valid = 1'b1; op = 3'd1; acc_mode = 1'b1; a = 8'hFF; b = 8'hFF; out_ready = 1'b0;
    apply_reset();
    apply_reset();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || y !== 8'h00 || zero !== 1'b1 || parity !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got valid=%b rdy=%b y=%h z=%b p=%b, want 0 1 00 1 0",
               out_valid, in_ready, y, zero, parity);
    end
  endtask

  task automatic test_truth_table();
    logic [WIDTH-1:0] exp_y [8];
    exp_y = '{8'hC0, 8'hFC, 8'h3F, 8'h03, 8'h3C, 8'hC3, 8'h0F, 8'hF0};
    for (int o = 0; o < 8; o++) begin
      step(1'b1, 3'(o), 1'b0, 8'hF0, 8'hCC, 1'b1);
      n_checks++;
      if (out_valid !== 1'b1 || y !== exp_y[o] || parity !== 1'b0 || zero !== 1'b0) begin
        n_fail++;
        $display("FAIL truth_op%0d: got valid=%b y=%h z=%b p=%b, want 1 %h 0 0",
                 o, out_valid, y, zero, parity, exp_y[o]);
      end
    end
    drain();
  endtask

  task automatic test_nand_sweep();
    logic [WIDTH-1:0] vals [4];
    logic [WIDTH-1:0] ey;
    vals = '{8'h00, 8'h0F, 8'hF0, 8'hFF};
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        step(1'b1, 3'd2, 1'b0, vals[i], vals[j], 1'b1);
        ey = ~(vals[i] & vals[j]);
        n_checks++;
        if (y !== ey || zero !== (i == 3 && j == 3)) begin
          n_fail++;
          $display("FAIL nand_%h_%h: got y=%h z=%b, want y=%h z=%b",
                   vals[i], vals[j], y, zero, ey, (i == 3 && j == 3));
        end
      end
    end
    drain();
  endtask

  task automatic test_acc_chain();
    logic [WIDTH-1:0] av [4];
    logic [WIDTH-1:0] ey [4];
    av = '{8'h01, 8'h02, 8'h04, 8'h80};
    ey = '{8'h01, 8'h03, 8'h07, 8'h87};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 3'd1, 1'b1, av[i], 8'hFF, 1'b1);
      n_checks++;
      if (y !== ey[i] || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL acc_or_%0d: got y=%h valid=%b, want %h 1", i, y, out_valid, ey[i]);
      end
    end
    step(1'b1, 3'd0, 1'b1, 8'h0F, 8'h00, 1'b1);
    n_checks++;
    if (y !== 8'h07) begin
      n_fail++;
      $display("FAIL acc_and: got y=%h, want 07", y);
    end
    step(1'b1, 3'd7, 1'b0, 8'h55, 8'h00, 1'b1);
    step(1'b1, 3'd1, 1'b1, 8'h00, 8'hFF, 1'b1);
    n_checks++;
    if (y !== 8'h07) begin
      n_fail++;
      $display("FAIL acc_hold: got y=%h, want 07", y);
    end
    drain();
  endtask

  task automatic test_backpressure();
    step(1'b1, 3'd4, 1'b0, 8'h11, 8'h22, 1'b0);
    n_checks++;
    if (got_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_rdy1: got %b, want 1", got_in_ready); end
    step(1'b1, 3'd0, 1'b0, 8'h44, 8'h0F, 1'b0);
    n_checks++;
    if (got_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_rdy2: got %b, want 1", got_in_ready); end
    step(1'b1, 3'd6, 1'b0, 8'hF0, 8'h00, 1'b0);
    n_checks++;
    if (got_in_ready !== 1'b0 || out_valid !== 1'b1 || y !== 8'h33) begin
      n_fail++;
      $display("FAIL bp_full: got rdy=%b valid=%b y=%h, want 0 1 33", got_in_ready, out_valid, y);
    end
    step(1'b1, 3'd6, 1'b0, 8'hF0, 8'h00, 1'b1);
    n_checks++;
    if (got_in_ready !== 1'b1 || y !== 8'h04) begin
      n_fail++;
      $display("FAIL bp_pop1: got rdy=%b y=%h, want 1 04", got_in_ready, y);
    end
    step(1'b0, 3'd0, 1'b0, 8'h00, 8'h00, 1'b1);
    n_checks++;
    if (y !== 8'h0F || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_pop2: got y=%h valid=%b, want 0F 1", y, out_valid);
    end
    step(1'b0, 3'd0, 1'b0, 8'h00, 8'h00, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0 || y !== 8'h0F) begin
      n_fail++;
      $display("FAIL bp_empty: got valid=%b y=%h, want 0 0F", out_valid, y);
    end
  endtask

  task automatic test_reset_midstream();
    step(1'b1, 3'd7, 1'b1, 8'h5A, 8'h00, 1'b0);
    step(1'b1, 3'd1, 1'b0, 8'h12, 8'h34, 1'b0);
    n_checks++;
    if (got_in_ready !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_fill: got rdy=%b valid=%b, want 0 1", in_ready, out_valid);
    end
    in_valid = 1'b1; out_ready = 1'b1;
    apply_reset();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || y !== 8'h00 || zero !== 1'b1 || parity !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid: got valid=%b rdy=%b y=%h z=%b p=%b, want 0 1 00 1 0",
               out_valid, in_ready, y, zero, parity);
    end
    step(1'b1, 3'd1, 1'b1, 8'h00, 8'hFF, 1'b1);
    n_checks++;
    if (y !== 8'h00 || zero !== 1'b1 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_acc: got y=%h z=%b valid=%b, want 00 1 1", y, zero, out_valid);
    end
    drain();
  endtask

  task automatic test_random_stream();
    item_t h;
    int    errs = 0;
    for (int c = 0; c < 10000; c++) begin
      step(1'($urandom_range(0, 3) != 0), 3'($urandom), 1'($urandom_range(0, 2) == 0),
           8'($urandom), 8'($urandom), 1'($urandom_range(0, 2) != 0));
      h = model_head();
      n_checks++;
      if (out_valid !== (mq.size() > 0) || y !== h.y || zero !== h.zero ||
          parity !== h.parity || got_in_ready !== exp_in_ready) begin
        n_fail++;
        errs++;
        if (errs <= 10)
          $display("FAIL rand_c%0d: got v=%b y=%h z=%b p=%b rdy=%b, want %b %h %b %b %b",
                   c, out_valid, y, zero, parity, got_in_ready,
                   (mq.size() > 0), h.y, h.zero, h.parity, exp_in_ready);
      end
    end
    drain();
    n_checks++;
    if (out_valid !== 1'b0 || mq.size() != 0) begin
      n_fail++;
      $display("FAIL rand_drain: got valid=%b model_left=%0d, want 0 0", out_valid, mq.size());
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; op = '0; acc_mode = 1'b0;
    a = '0; b = '0; out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_truth_table();
    test_nand_sweep();
    test_acc_chain();
    test_backpressure();
    test_reset_midstream();
    test_random_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/logic_unit_pipe.md
# logic_unit_pipe

Parametrised, registered bitwise logic unit: applies one of eight two-operand logic functions (AND, OR, NAND, NOR, XOR, XNOR, NOT, PASS) to WIDTH-bit operands and delivers results through a 2-entry output buffer with valid/ready handshakes on both sides. An accumulate mode substitutes an internal accumulator for operand b and writes each result back, enabling chained reductions across a stream. It generalises the single-bit combinational NAND gates into the first streaming member of the logic library, used in front of datapath blocks that apply backpressure.

## Interface
- WIDTH, 8, operand/result width in bits (≥1)
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset, sampled on clk rising edge
- in_valid  in  1  input transaction present
- in_ready  out  1  block can accept; transfer when in_valid & in_ready at clk edge
- op  in  3  function: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT a, 7 PASS a
- acc_mode  in  1  1: operand b is replaced by accumulator; result written back to accumulator
- a  in  WIDTH  operand a
- b  in  WIDTH  operand b (ignored when acc_mode=1)
- out_valid  out  1  buffer head holds a result
- out_ready  in  1  consumer accepts; transfer when out_valid & out_ready at clk edge
- y  out  WIDTH  result at buffer head
- zero  out  1  y == 0 (head entry)
- parity  out  1  XOR-reduction of y (head entry)

## Operation
- Reset (rst_n=0 at clk edge): buffer emptied, accumulator cleared to 0, out_valid=0, in_ready=1, y=0, zero=1, parity=0. Reset mid-transfer drops all buffered and in-flight data; no transfer completes on a reset edge.
- Operand select: bsel = acc_mode ? acc : b. Result r = f(op, a, bsel), computed combinationally from inputs and current acc, bitwise over WIDTH bits.
- NOT and PASS ignore bsel, but in acc_mode they still write r into acc.
- Accept (in_valid & in_ready): r pushed to buffer tail; if acc_mode=1, acc <= r on the same edge. acc unchanged on non-accepted cycles or acc_mode=0 accepts.
- Buffer: 2-entry FIFO of {y, zero, parity}; zero/parity computed on push, stored with entry. Head drives y/zero/parity; when empty, outputs hold last-popped value (0/1/0 after reset).
- in_ready = (count < 2) | out_ready — registered-count based: in_ready depends combinationally on out_ready only when count==2 (pop frees a slot same cycle). No combinational path from in_valid to out_valid.
- Simultaneous push and pop: count unchanged, order preserved; with count==1 the new entry becomes head on the next cycle.
- Pop when empty and push when full-without-pop cannot occur by construction.
- Unknown (X) inputs on a/b propagate to y per standard Verilog operator semantics; not masked.

## Timing
- Latency: 1 cycle; accepted at edge N, result on y with out_valid=1 from edge N (visible in cycle N+1) if buffer was empty.
- Throughput: 1 transaction/cycle sustained while out_ready=1.
- With out_ready=0: two accepts fill buffer; in_ready falls to 0 after the second accept edge; first out_ready=1 cycle pops head and allows a simultaneous push.
- Accumulator chain: back-to-back acc_mode accepts on consecutive cycles each see the acc value written by the previous edge; no bubble.
- out_valid, y, zero, parity, in_ready (count part) are registered-derived; no output glitches from in_valid.

## Test plan
- Truth table, WIDTH=8, out_ready=1: a=8'hF0, b=8'hCC, ops 0..7 → y = C0, FC, 3F, 03, 3C, C3, 0F, F0; parity 0,0,0,0,0,0,0,0; each one cycle after accept.
- NAND equivalence sweep: a,b over {00,0F,F0,FF} exhaustive, op=2 → y = ~(a&b), zero=1 only when a=b=FF.
- Accumulate chain: reset, then acc_mode=1 op=1 (OR) with a=01,02,04,80 on consecutive cycles → y = 01,03,07,87; then op=0 (AND) a=0F → y=07; acc_mode=0 leaves acc=07.
- Backpressure: out_ready=0, send 3 transactions → in_ready=0 after 2 accepts, third held; raise out_ready → results pop in order, third accepted on the same edge as first pop, no loss/duplication.
- Reset mid-stream: buffer full, acc=5A, assert rst_n=0 one cycle → out_valid=0, in_ready=1, y=00, zero=1, acc=00 (verify with acc_mode OR a=00 → y=00).
- Random stream with random in_valid/out_ready, 10k cycles, vs. reference model → every accepted item emerges exactly once, in order, with correct y/zero/parity.
